// File: rtl/heart_spawner.sv
// Heart pickup spawner: schedules, drops, holds and removes a collectible heart,
// issuing a one-cycle heal pulse to whichever player touches it.
module heart_spawner #(
  parameter int unsigned SPAWN_DELAY = 600,
  parameter int unsigned LIFETIME    = 300,
  parameter logic [9:0]  FLOOR_Y     = 10'd400,
  parameter logic [9:0]  FALL_STEP   = 10'd2,
  parameter logic [9:0]  X_MIN       = 10'd64,
  parameter logic [9:0]  SEED        = 10'h2A5,
  parameter int unsigned SIZE        = 16,
  parameter int unsigned PLAYER_W    = 32,
  parameter int unsigned PLAYER_H    = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       game_on,
  input  logic [9:0] P1_X,
  input  logic [9:0] P1_Y,
  input  logic [9:0] P2_X,
  input  logic [9:0] P2_Y,
  output logic [9:0] Box_X,
  output logic [9:0] Box_Y,
  output logic       box_active,
  output logic       p1_heal,
  output logic       p2_heal
);

  localparam logic [9:0]  C_SPAWN = 10'(SPAWN_DELAY);
  localparam logic [9:0]  C_LIFE  = 10'(LIFETIME);
  localparam logic [10:0] C_SIZE  = 11'(SIZE);
  localparam logic [10:0] C_PW    = 11'(PLAYER_W);
  localparam logic [10:0] C_PH    = 11'(PLAYER_H);

  typedef enum logic [1:0] {StWait, StFall, StLanded} state_e;

  state_e      r_state, w_state_d;
  logic [9:0]  r_cnt, w_cnt_d;
  logic [9:0]  r_lfsr, w_lfsr_d;
  logic [9:0]  r_box_x, w_box_x_d;
  logic [9:0]  r_box_y, w_box_y_d;
  logic        r_fc_d;
  logic        r_active, w_active_d;
  logic        r_p1_heal, w_p1_heal_d;
  logic        r_p2_heal, w_p2_heal_d;

  logic        w_tick;
  logic        w_hit1, w_hit2;
  logic [10:0] w_fall_sum;

  assign w_tick = frame_clk & ~r_fc_d;

  // 11-bit sums keep the overlap and landing tests free of wraparound.
  assign w_hit1 = ({1'b0, r_box_x} < {1'b0, P1_X} + C_PW) &&
                  ({1'b0, P1_X} < {1'b0, r_box_x} + C_SIZE) &&
                  ({1'b0, r_box_y} < {1'b0, P1_Y} + C_PH) &&
                  ({1'b0, P1_Y} < {1'b0, r_box_y} + C_SIZE);
  assign w_hit2 = ({1'b0, r_box_x} < {1'b0, P2_X} + C_PW) &&
                  ({1'b0, P2_X} < {1'b0, r_box_x} + C_SIZE) &&
                  ({1'b0, r_box_y} < {1'b0, P2_Y} + C_PH) &&
                  ({1'b0, P2_Y} < {1'b0, r_box_y} + C_SIZE);
  assign w_fall_sum = {1'b0, r_box_y} + {1'b0, FALL_STEP};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= StWait;
      r_cnt     <= C_SPAWN;
      r_lfsr    <= SEED;
      r_fc_d    <= 1'b0;
      r_box_x   <= '0;
      r_box_y   <= '0;
      r_active  <= 1'b0;
      r_p1_heal <= 1'b0;
      r_p2_heal <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_lfsr    <= w_lfsr_d;
      r_fc_d    <= frame_clk;
      r_box_x   <= w_box_x_d;
      r_box_y   <= w_box_y_d;
      r_active  <= w_active_d;
      r_p1_heal <= w_p1_heal_d;
      r_p2_heal <= w_p2_heal_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_box_x_d   = r_box_x;
    w_box_y_d   = r_box_y;
    w_active_d  = r_active;
    w_p1_heal_d = 1'b0;
    w_p2_heal_d = 1'b0;
    w_lfsr_d    = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    if (w_tick) begin
      if (!game_on) begin
        w_state_d  = StWait;
        w_cnt_d    = C_SPAWN;
        w_active_d = 1'b0;
      end else begin
        case (r_state)
          StWait: begin
            if (r_cnt == '0) begin
              w_box_x_d  = X_MIN + {1'b0, r_lfsr[8:0]};
              w_box_y_d  = '0;
              w_active_d = 1'b1;
              w_state_d  = StFall;
            end else begin
              w_cnt_d = r_cnt - 10'd1;
            end
          end
          StFall, StLanded: begin
            if (w_hit1 || w_hit2) begin
              // Player 1 takes precedence on a simultaneous touch.
              w_p1_heal_d = w_hit1;
              w_p2_heal_d = ~w_hit1;
              w_state_d   = StWait;
              w_cnt_d     = C_SPAWN;
              w_active_d  = 1'b0;
            end else if (r_state == StFall) begin
              if (w_fall_sum >= {1'b0, FLOOR_Y}) begin
                w_box_y_d = FLOOR_Y;
                w_cnt_d   = C_LIFE;
                w_state_d = StLanded;
              end else begin
                w_box_y_d = w_fall_sum[9:0];
              end
            end else if (r_cnt == '0) begin
              w_state_d  = StWait;
              w_cnt_d    = C_SPAWN;
              w_active_d = 1'b0;
            end else begin
              w_cnt_d = r_cnt - 10'd1;
            end
          end
          default: begin
            w_state_d  = StWait;
            w_cnt_d    = C_SPAWN;
            w_active_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    Box_X      = r_box_x;
    Box_Y      = r_box_y;
    box_active = r_active;
    p1_heal    = r_p1_heal;
    p2_heal    = r_p2_heal;
  end

endmodule

// File: tb/tb_heart_spawner.sv
// Self-checking bench for heart_spawner: directed scenarios plus randomized ticks
// compared against a per-tick behavioural model of the pickup rules.
module tb_heart_spawner;

  localparam int unsigned SPAWN_DELAY = 3;
  localparam int unsigned LIFETIME    = 4;
  localparam int          FLOOR       = 40;
  localparam int          STEP        = 8;
  localparam int          XMIN        = 64;
  localparam logic [9:0]  SEED        = 10'h2A5;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       game_on = 1'b0;
  logic [9:0] P1_X = 10'd0, P1_Y = 10'd300, P2_X = 10'd0, P2_Y = 10'd300;
  logic [9:0] Box_X, Box_Y;
  logic       box_active, p1_heal, p2_heal;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [9:0] m_lfsr;
  int m_x, m_y, m_cnt;
  bit m_act, m_landed, m_h1, m_h2;

  heart_spawner #(
    .SPAWN_DELAY(SPAWN_DELAY), .LIFETIME(LIFETIME), .FLOOR_Y(10'd40), .FALL_STEP(10'd8),
    .X_MIN(10'd64), .SEED(SEED), .SIZE(16), .PLAYER_W(32), .PLAYER_H(64)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_on(game_on),
    .P1_X(P1_X), .P1_Y(P1_Y), .P2_X(P2_X), .P2_Y(P2_Y),
    .Box_X(Box_X), .Box_Y(Box_Y), .box_active(box_active),
    .p1_heal(p1_heal), .p2_heal(p2_heal)
  );

  always #5 Clk = ~Clk;

  // Free-running x^10+x^7+1 sequence, reset to the seed.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic bit overlaps(input int px, input int py);
    return (m_x < px + 32) && (px < m_x + 16) && (m_y < py + 64) && (py < m_y + 16);
  endfunction

  task automatic model_tick(input logic [9:0] lf);
    m_h1 = 0;
    m_h2 = 0;
    if (!game_on) begin
      m_act = 0; m_landed = 0; m_cnt = SPAWN_DELAY;
    end else if (!m_act) begin
      if (m_cnt == 0) begin
        m_x = XMIN + (int'(lf) % 512); m_y = 0; m_act = 1; m_landed = 0;
      end else m_cnt--;
    end else if (overlaps(int'(P1_X), int'(P1_Y))) begin
      m_h1 = 1; m_act = 0; m_cnt = SPAWN_DELAY;
    end else if (overlaps(int'(P2_X), int'(P2_Y))) begin
      m_h2 = 1; m_act = 0; m_cnt = SPAWN_DELAY;
    end else if (!m_landed) begin
      if (m_y + STEP >= FLOOR) begin
        m_y = FLOOR; m_cnt = LIFETIME; m_landed = 1;
      end else m_y += STEP;
    end else if (m_cnt == 0) begin
      m_act = 0; m_cnt = SPAWN_DELAY;
    end else m_cnt--;
  endtask

  task automatic park();
    P1_X = 10'd0; P1_Y = 10'd300; P2_X = 10'd0; P2_Y = 10'd300;
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    m_x = 0; m_y = 0; m_cnt = SPAWN_DELAY; m_act = 0; m_landed = 0; m_h1 = 0; m_h2 = 0;
  endtask

  // Produce one frame_clk rise; returns 1 ns after the tick edge with frame_clk still high.
  task automatic tick(output logic [9:0] lf);
    @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    frame_clk = 1'b1;
    lf = m_lfsr;
    model_tick(lf);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] lf;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    n_checks++;
    if ({Box_X, Box_Y, box_active, p1_heal, p2_heal} !== 23'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got x=%0d y=%0d act=%0b h=%0b%0b expected all 0",
               Box_X, Box_Y, box_active, p1_heal, p2_heal);
    end
    apply_reset();
    lf = '0;
  endtask

  task automatic test_spawn();
    logic [9:0] lf;
    int ex;
    apply_reset();
    game_on = 1'b1;
    park();
    for (int t = 1; t <= 3; t++) begin
      tick(lf);
      n_checks++;
      if (box_active !== 1'b0) begin
        n_errors++;
        $display("FAIL spawn_wait_t%0d: got act=%0b expected 0", t, box_active);
      end
    end
    tick(lf);
    ex = XMIN + (int'(lf) % 512);
    n_checks++;
    if (box_active !== 1'b1 || Box_Y !== 10'd0) begin
      n_errors++;
      $display("FAIL spawn_t4: got act=%0b y=%0d expected act=1 y=0", box_active, Box_Y);
    end
    n_checks++;
    if (int'(Box_X) != ex || Box_X < 10'd64 || Box_X > 10'd575) begin
      n_errors++;
      $display("FAIL spawn_x: got %0d expected %0d", Box_X, ex);
    end
  endtask

  task automatic test_fall_lifetime();
    logic [9:0] lf;
    for (int t = 5; t <= 9; t++) begin
      tick(lf);
      n_checks++;
      if (int'(Box_Y) != (t - 4) * 8 || box_active !== 1'b1) begin
        n_errors++;
        $display("FAIL fall_t%0d: got y=%0d act=%0b expected y=%0d act=1",
                 t, Box_Y, box_active, (t - 4) * 8);
      end
    end
    for (int t = 10; t <= 13; t++) begin
      tick(lf);
      n_checks++;
      if (Box_Y !== 10'd40 || box_active !== 1'b1) begin
        n_errors++;
        $display("FAIL landed_t%0d: got y=%0d act=%0b expected y=40 act=1", t, Box_Y, box_active);
      end
    end
    tick(lf);
    n_checks++;
    if (box_active !== 1'b0 || Box_Y !== 10'd40) begin
      n_errors++;
      $display("FAIL despawn_t14: got act=%0b y=%0d expected act=0 y=40", box_active, Box_Y);
    end
  endtask

  task automatic test_pickup();
    logic [9:0] lf;
    apply_reset();
    game_on = 1'b1;
    park();
    repeat (4) tick(lf);
    P2_X = 10'(m_x + 16);
    P2_Y = 10'd0;
    tick(lf);
    n_checks++;
    if (p2_heal !== 1'b0 || box_active !== 1'b1) begin
      n_errors++;
      $display("FAIL pickup_edge: got heal=%0b act=%0b expected heal=0 act=1", p2_heal, box_active);
    end
    P2_X = 10'(m_x + 15);
    tick(lf);
    n_checks++;
    if (p2_heal !== 1'b1 || p1_heal !== 1'b0 || box_active !== 1'b0) begin
      n_errors++;
      $display("FAIL pickup_p2: got h1=%0b h2=%0b act=%0b expected h1=0 h2=1 act=0",
               p1_heal, p2_heal, box_active);
    end
    @(posedge Clk);
    #1;
    n_checks++;
    if (p2_heal !== 1'b0) begin
      n_errors++;
      $display("FAIL pickup_pulse_width: got h2=%0b expected 0", p2_heal);
    end
    park();
    for (int t = 1; t <= 4; t++) begin
      tick(lf);
      n_checks++;
      if (box_active !== (t == 4)) begin
        n_errors++;
        $display("FAIL respawn_t%0d: got act=%0b expected %0b", t, box_active, t == 4);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [9:0] lf;
    apply_reset();
    game_on = 1'b1;
    park();
    repeat (4) tick(lf);
    P1_X = 10'(m_x); P1_Y = 10'd0; P2_X = 10'(m_x); P2_Y = 10'd0;
    tick(lf);
    n_checks++;
    if (p1_heal !== 1'b1 || p2_heal !== 1'b0 || box_active !== 1'b0) begin
      n_errors++;
      $display("FAIL simultaneous: got h1=%0b h2=%0b act=%0b expected h1=1 h2=0 act=0",
               p1_heal, p2_heal, box_active);
    end
    park();
  endtask

  task automatic test_game_off();
    logic [9:0] lf;
    int bad;
    apply_reset();
    game_on = 1'b1;
    park();
    repeat (6) tick(lf);
    P1_X = 10'(m_x); P1_Y = 10'(m_y);
    game_on = 1'b0;
    tick(lf);
    n_checks++;
    if (box_active !== 1'b0 || p1_heal !== 1'b0 || p2_heal !== 1'b0) begin
      n_errors++;
      $display("FAIL game_off_drop: got act=%0b h1=%0b h2=%0b expected all 0",
               box_active, p1_heal, p2_heal);
    end
    park();
    bad = 0;
    repeat (10) begin
      tick(lf);
      if (box_active !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL game_off_hold: got %0d active ticks expected 0", bad);
    end
    game_on = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick(lf);
      n_checks++;
      if (box_active !== (t == 4)) begin
        n_errors++;
        $display("FAIL game_on_restart_t%0d: got act=%0b expected %0b", t, box_active, t == 4);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] lf;
    apply_reset();
    game_on = 1'b1;
    park();
    repeat (10) tick(lf);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    n_checks++;
    if ({Box_X, Box_Y, box_active, p1_heal, p2_heal} !== 23'd0) begin
      n_errors++;
      $display("FAIL async_reset: got x=%0d y=%0d act=%0b expected 0 0 0",
               Box_X, Box_Y, box_active);
    end
    apply_reset();
  endtask

  task automatic test_frame_hold();
    logic [9:0] lf;
    apply_reset();
    game_on = 1'b1;
    park();
    repeat (4) tick(lf);
    tick(lf);
    n_checks++;
    if (Box_Y !== 10'd8) begin
      n_errors++;
      $display("FAIL hold_first: got y=%0d expected 8", Box_Y);
    end
    repeat (4) @(posedge Clk);
    #1;
    n_checks++;
    if (Box_Y !== 10'd8 || box_active !== 1'b1) begin
      n_errors++;
      $display("FAIL hold_single_update: got y=%0d act=%0b expected y=8 act=1", Box_Y, box_active);
    end
  endtask

  task automatic place(output logic [9:0] px, output logic [9:0] py);
    int tx, ty;
    if ($urandom_range(0, 2) == 0) begin
      px = 10'd0; py = 10'd300;
    end else begin
      tx = m_x + int'($urandom_range(0, 80)) - 50;
      ty = m_y + int'($urandom_range(0, 100)) - 70;
      if (tx < 0) tx = 0;
      if (ty < 0) ty = 0;
      px = 10'(tx); py = 10'(ty);
    end
  endtask

  task automatic test_random();
    logic [9:0] lf, ax, ay, bx, by;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      game_on = ($urandom_range(0, 19) != 0);
      place(ax, ay);
      place(bx, by);
      P1_X = ax; P1_Y = ay; P2_X = bx; P2_Y = by;
      tick(lf);
      n_checks++;
      if (box_active !== m_act || p1_heal !== m_h1 || p2_heal !== m_h2 ||
          (m_act && (int'(Box_X) != m_x || int'(Box_Y) != m_y))) begin
        n_errors++;
        $display("FAIL random_%0d: got x=%0d y=%0d act=%0b h=%0b%0b expected x=%0d y=%0d act=%0b h=%0b%0b",
                 i, Box_X, Box_Y, box_active, p1_heal, p2_heal, m_x, m_y, m_act, m_h1, m_h2);
      end
      @(posedge Clk);
      #1;
      n_checks++;
      if (p1_heal !== 1'b0 || p2_heal !== 1'b0) begin
        n_errors++;
        $display("FAIL random_pulse_%0d: got h=%0b%0b expected 00", i, p1_heal, p2_heal);
      end
    end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_fall_lifetime();
    test_pickup();
    test_simultaneous();
    test_game_off();
    test_async_reset();
    test_frame_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
